// File: rtl/cpu_types_pkg.sv
// Core datapath types shared across pipeline stages.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selections, the link register index and the writeback FSM state type.
package data_path_muxs_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    RD_DEST   = 2'd0,
    RT_DEST   = 2'd1,
    LINK_DEST = 2'd2
  } reg_dest_mux_selection;

  localparam regbits_t LINK_REG = 5'd31;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;
endpackage

// File: rtl/reg_file_core.sv
// Register file: 1 write / 2 read ports, r0 hardwired to zero, async clear.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module reg_file_core
  import cpu_types_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     wen,
  input  regbits_t waddr,
  input  word_t    wdata,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output word_t    rdat1,
  output word_t    rdat2
);

  word_t regs_q [NUM_REGS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdat1 = regs_q[rsel1];
    rdat2 = regs_q[rsel2];
`ifdef WB_BYPASS_EN
    if (wen && (rsel1 == waddr)) rdat1 = wdata;
    if (wen && (rsel2 == waddr)) rdat2 = wdata;
`endif
    // r0 overrides any bypass match
    if (rsel1 == '0) rdat1 = '0;
    if (rsel2 == '0) rdat2 = '0;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: destination decode, register commit, sticky halt and commit counter.
// Optional WB_BYPASS_EN enables same-cycle read bypass inside reg_file_core.
module wb_stage
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  WEN_MEM_WB,
  input  reg_dest_mux_selection reg_dest_MEM_WB,
  input  logic [31:0]           mem_data_MEM_WB,
  input  logic [4:0]            Rt_MEM_WB,
  input  logic [4:0]            Rd_MEM_WB,
  input  logic                  halt_MEM_WB,
  input  logic [4:0]            rsel1,
  input  logic [4:0]            rsel2,
  output logic [31:0]           rdat1,
  output logic [31:0]           rdat2,
  output logic                  wb_wen,
  output logic [4:0]            wb_wsel,
  output logic                  halt,
  output logic [CNT_W-1:0]      commit_cnt
);

  wb_state_t        state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    unique case (reg_dest_MEM_WB)
      RT_DEST:   wb_wsel = Rt_MEM_WB;
      LINK_DEST: wb_wsel = LINK_REG;
      default:   wb_wsel = Rd_MEM_WB;
    endcase
  end

  // nRST gating keeps wb_wen (and any bypass) at 0 while reset is held
  assign wb_wen = WEN_MEM_WB && (wb_wsel != '0) && (state_q == RUN) && nRST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:     if (halt_MEM_WB) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign halt = (state_q == HALTED);

  always_comb begin
    cnt_d = cnt_q;
    if (wb_wen && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign commit_cnt = cnt_q;

  reg_file_core #(
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .CLK   (CLK),
    .nRST  (nRST),
    .wen   (wb_wen),
    .waddr (wb_wsel),
    .wdata (mem_data_MEM_WB),
    .rsel1 (rsel1),
    .rsel2 (rsel2),
    .rdat1 (rdat1),
    .rdat2 (rdat2)
  );

endmodule
